// File: rtl/mpu_pkg.sv
`default_nettype none
// ============================================================================
// mpu_pkg : shared constants and FSM encoding for the MPU RAM arbiter
// Rev 1.0 : initial release
// ============================================================================
package mpu_pkg;

   localparam int ADDR_W      = 15;
   localparam int LANE_ADR_W  = 12;
   localparam int LANES       = 8;
   localparam int FETCH_BYTES = 6;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      F_ACK = 2'd1,
      H_ACK = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/mpu_lane_rotate.sv
`default_nettype none
// ============================================================================
// mpu_lane_rotate : per-lane word addresses for an unaligned 6-byte fetch and
//                   rotation of the eight lane bytes into fetch byte order
// Rev 1.0 : initial release
// ============================================================================
module mpu_lane_rotate
   import mpu_pkg::*;
(
   input  logic [ADDR_W-1:0]            addr,
   input  logic [2:0]                   rot,
   input  logic [LANES*8-1:0]           lane_dat,
   output logic [LANES*LANE_ADR_W-1:0]  lane_adr,
   output logic [FETCH_BYTES*8-1:0]     fetch_dat
);

   // Lane k holds the window byte at word (addr+7-k)>>3; the 15-bit add wraps
   // the address space so a fetch near the top continues at byte 0.
   for (genvar k = 0; k < LANES; k++) begin : g_lane_adr
      logic [ADDR_W-1:0] w_sum;
      assign w_sum = addr + ADDR_W'(LANES - 1 - k);
      assign lane_adr[k*LANE_ADR_W +: LANE_ADR_W] = w_sum[ADDR_W-1:3];
   end

   for (genvar j = 0; j < FETCH_BYTES; j++) begin : g_byte_rot
      logic [2:0] w_sel;
      assign w_sel = rot + 3'(j);
      assign fetch_dat[j*8 +: 8] = lane_dat[{w_sel, 3'b000} +: 8];
   end

endmodule
`default_nettype wire

// File: rtl/mpu_ram_arbiter.sv
`default_nettype none
// ============================================================================
// mpu_ram_arbiter : arbitrates an instruction fetch port and a byte host port
//                   onto eight byte-wide synchronous lane RAMs
// Rev 1.0 : initial release
// ============================================================================
module mpu_ram_arbiter
   import mpu_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic                          sys_clk,
   input  logic                          sys_rst,
   input  logic                          f_req_i,
   input  logic [ADDR_W-1:0]             f_addr_i,
   output logic                          f_ack_o,
   output logic [FETCH_BYTES*8-1:0]      f_data_o,
   input  logic                          h_req_i,
   input  logic                          h_we_i,
   input  logic [ADDR_W-1:0]             h_addr_i,
   input  logic [7:0]                    h_dat_i,
   output logic [7:0]                    h_dat_o,
   output logic                          h_ack_o,
   output logic [LANES*LANE_ADR_W-1:0]   ram_adr_o,
   output logic [LANES-1:0]              ram_we_o,
   output logic [7:0]                    ram_dat_o,
   input  logic [LANES*8-1:0]            ram_dat_i
);

   state_t     r_state;
   logic [3:0] r_loss;
   logic [2:0] r_rot;
   logic       r_rd;

   logic                          w_idle;
   logic                          w_grant_f;
   logic                          w_grant_h;
   logic [LANES*LANE_ADR_W-1:0]   w_fetch_adr;
   logic [FETCH_BYTES*8-1:0]      w_fetch_dat;

   assign w_idle    = (r_state == IDLE);
   assign w_grant_f = w_idle & f_req_i & ~(h_req_i & (r_loss == 4'(STARVE_MAX)));
   assign w_grant_h = w_idle & h_req_i & ~w_grant_f;

   mpu_lane_rotate u_rotate (
      .addr      (f_addr_i),
      .rot       (r_rot),
      .lane_dat  (ram_dat_i),
      .lane_adr  (w_fetch_adr),
      .fetch_dat (w_fetch_dat)
   );

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_state <= IDLE;
         r_loss  <= 4'd0;
         r_rot   <= 3'd0;
         r_rd    <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (w_grant_f) begin
                  r_state <= F_ACK;
                  r_rot   <= f_addr_i[2:0];
               end else if (w_grant_h) begin
                  r_state <= H_ACK;
                  r_rot   <= h_addr_i[2:0];
                  r_rd    <= ~h_we_i;
               end
            end
            F_ACK:   r_state <= IDLE;
            H_ACK:   r_state <= IDLE;
            default: r_state <= IDLE;
         endcase

         if (!h_req_i || w_grant_h)
            r_loss <= 4'd0;
         else if (w_grant_f)
            r_loss <= r_loss + 4'd1;
      end
   end

   // A host write granted in the reset cycle still reaches the RAM; every
   // other RAM access is squashed while reset is high.
   always_comb begin
      ram_adr_o = '0;
      ram_we_o  = '0;
      ram_dat_o = '0;
      if (w_grant_f) begin
         if (!sys_rst)
            ram_adr_o = w_fetch_adr;
      end else if (w_grant_h) begin
         if (h_we_i) begin
            ram_dat_o = h_dat_i;
            for (int k = 0; k < LANES; k++) begin
               if (h_addr_i[2:0] == 3'(k)) begin
                  ram_adr_o[k*LANE_ADR_W +: LANE_ADR_W] = h_addr_i[ADDR_W-1:3];
                  ram_we_o[k]                           = 1'b1;
               end
            end
         end else if (!sys_rst) begin
            ram_adr_o = {LANES{h_addr_i[ADDR_W-1:3]}};
         end
      end
   end

   assign f_ack_o  = (r_state == F_ACK) & ~sys_rst;
   assign h_ack_o  = (r_state == H_ACK) & ~sys_rst;
   assign f_data_o = f_ack_o ? w_fetch_dat : '0;
   assign h_dat_o  = (h_ack_o & r_rd) ? ram_dat_i[{r_rot, 3'b000} +: 8] : 8'h00;

endmodule
`default_nettype wire
